// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions, used by the host transmitter and the keyboard receiver.
// Contents: transmitter state encoding, default timing constants, parity helper.
package ps2_pkg;

    localparam int unsigned INHIBIT_CYCLES_DEF = 5000;    // 100 us at 50 MHz
    localparam int unsigned TIMEOUT_CYCLES_DEF = 750000;  // 15 ms at 50 MHz

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_STOP     = 3'd5,
        ST_ACK      = 3'd6,
        ST_WAIT_REL = 3'd7
    } ps2_tx_state_e;

    // Odd parity: total number of ones across byte + parity bit is odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer and falling-edge detector for one PS/2 pad line.
// Ports: clk, rst (sync, active-high), line_i (raw pad), level_o (synchronized
// level), fall_c (combinational falling-edge strobe from the synchronizer flops).
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_c
);

    // sync_q[0] is the newer sample, sync_q[1] the older one; lines idle high.
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

    assign level_o = sync_q[0];
    assign fall_c  = sync_q[1] & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 8 data bits LSB
// first, odd parity, stop, device ACK, wait for bus release).
// Ports: clk, rst (sync, active-high); ps2_clk/ps2_data pad inputs;
// ps2_clk_oe/ps2_data_oe open-drain pull-low enables; wr/wdata command write;
// busy, done (one-cycle), ack_err and timeout (sticky until next accepted wr).
// Optional watchdog: define PS2_TX_TIMEOUT_EN; otherwise timeout is tied to 0.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    logic clk_lvl, clk_fall_c, data_lvl, data_fall_c;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk),
        .level_o (clk_lvl),
        .fall_c  (clk_fall_c)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data),
        .level_o (data_lvl),
        .fall_c  (data_fall_c)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [3:0]       bit_q, bit_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        par_d     = par_q;
        inh_d     = inh_q;
        bit_d     = bit_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
        timeout_d = timeout_q;
        wd_d      = wd_q + WD_W'(1);
`endif

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (wr) begin
                    byte_d    = wdata;
                    par_d     = odd_parity(wdata);
                    ack_err_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    inh_d     = '0;
                    bit_d     = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            // Clock held low INHIBIT_CYCLES cycles, then one extra cycle with start bit.
            ST_INHIBIT: begin
                if (inh_q == INH_W'(INHIBIT_CYCLES)) begin
                    clk_oe_d = 1'b0;
                    state_d  = ST_RTS;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                    if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                        data_oe_d = 1'b1;
                    end
                end
            end
            ST_RTS: begin
                if (clk_fall_c) begin
                    data_oe_d = ~byte_q[0];
                    bit_d     = 4'd1;
                    state_d   = ST_DATA;
                end
            end
            // bit_q holds the number of falling edges seen so far.
            ST_DATA: begin
                if (clk_fall_c) begin
                    if (bit_q == 4'd8) begin
                        data_oe_d = ~par_q;
                        state_d   = ST_PARITY;
                    end else begin
                        data_oe_d = ~byte_q[bit_q[2:0]];
                    end
                    bit_d = bit_q + 4'd1;
                end
            end
            ST_PARITY: begin
                if (clk_fall_c) begin
                    data_oe_d = 1'b0;
                    bit_d     = 4'd10;
                    state_d   = ST_STOP;
                end
            end
            // Falling edge 11: device pulls data low to acknowledge.
            ST_STOP: begin
                if (clk_fall_c) begin
                    bit_d = 4'd11;
                    if (!data_lvl) begin
                        state_d = ST_ACK;
                    end else begin
                        ack_err_d = 1'b1;
                        state_d   = ST_WAIT_REL;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = ~ack_err_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog runs from leaving INHIBIT until WAIT_REL exits; expiry aborts.
        if (state_q == ST_IDLE || state_q == ST_INHIBIT) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_d      = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            par_q     <= 1'b0;
            inh_q     <= '0;
            bit_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            inh_q     <= inh_d;
            bit_q     <= bit_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device model on the open-drain lines
// and a frame reference model computed from the byte (LSB first, odd parity, stop=1).
module tb_ps2_host_tx;

    localparam int unsigned INH = 5000;
    localparam int unsigned TMO = 3000;
    localparam int          H   = 10;     // device clock half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_w, ps2_data_w;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout;

    int checks = 0;
    int errors = 0;

    // Wired-AND open-drain bus: either side may pull low.
    assign ps2_clk_w  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_w = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk_w),
        .ps2_data    (ps2_data_w),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .wr          (wr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    always #10 clk = ~clk;

    // Done-pulse counter and busy-gap monitor.
    int done_cnt  = 0;
    int busy_gap  = 0;
    bit mon_en    = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !busy && !done && done_cnt == 0) busy_gap++;
        if (done) done_cnt++;
    end

    // Reference frame: data LSB first, then parity making the ones count odd, then stop=1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic send_wr(input logic [7:0] b);
        @(negedge clk);
        wdata = b;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    // Measures request-to-send: cycles with clock only, then with clock+start bit.
    task automatic measure_inhibit(output int n_clk, output int n_both);
        n_clk = 0;
        n_both = 0;
        for (int g = 0; g < INH + 100 && ps2_clk_oe; g++) begin
            if (ps2_data_oe) n_both++;
            else n_clk++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Device model: clocks 11 bits, samples host data on rising edges,
    // optionally ACKs, and can inject a wr or rst at a given falling edge.
    task automatic device_xfer(input bit do_ack, input int wr_at, input int rst_at,
                               output logic [9:0] bits, output bit ok,
                               output logic snap_clk_oe, output logic snap_data_oe,
                               output logic snap_busy);
        bits = '0;
        ok = 1'b0;
        snap_clk_oe = 1'bx; snap_data_oe = 1'bx; snap_busy = 1'bx;
        for (int g = 0; g < 1000; g++) begin
            if (!ps2_clk_oe && ps2_data_oe) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                snap_clk_oe = ps2_clk_oe; snap_data_oe = ps2_data_oe; snap_busy = busy;
                rst = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            if (i == wr_at) begin
                wdata = 8'hAA;
                wr    = 1'b1;
            end
            for (int k = 0; k < H; k++) begin
                @(negedge clk);
                wr = 1'b0;
            end
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = ps2_data_w;
            if (i == 10 && do_ack) begin
                repeat (H / 2) @(negedge clk);
                dev_data = 1'b0;
                repeat (H - H / 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wr = 1'b1;
        wdata = 8'hED;
        repeat (3) @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
        checks++; if ({busy, done, ack_err, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, ack_err, timeout}); end
        rst = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wr_ignored busy got %b want 0", busy); end
    endtask

    // Full transfer with an ACKing device; checks frame, timing and flags.
    task automatic run_good(input string name, input logic [7:0] b, input bit check_inh);
        int nc, nb;
        logic [9:0] bits;
        bit ok, idle_ok;
        logic s0, s1, s2;
        done_cnt = 0; busy_gap = 0;
        send_wr(b);
        mon_en = 1'b1;
        measure_inhibit(nc, nb);
        if (check_inh) begin
            checks++; if (nc != INH) begin errors++; $display("FAIL %s inhibit_len got %0d want %0d", name, nc, INH); end
            checks++; if (nb != 1) begin errors++; $display("FAIL %s start_overlap got %0d want 1", name, nb); end
        end
        device_xfer(1'b1, 0, 0, bits, ok, s0, s1, s2);
        wait_idle(idle_ok);
        @(negedge clk);
        mon_en = 1'b0;
        checks++; if (!ok || !idle_ok) begin errors++; $display("FAIL %s handshake got rts=%0b idle=%0b want 1 1", name, ok, idle_ok); end
        checks++; if (bits !== ref_frame(b)) begin errors++; $display("FAIL %s frame got %b want %b", name, bits, ref_frame(b)); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt); end
        checks++; if (busy_gap != 0) begin errors++; $display("FAIL %s busy_gap got %0d want 0", name, busy_gap); end
        checks++; if ({ack_err, timeout} !== 2'b00) begin errors++; $display("FAIL %s err_flags got %b want 00", name, {ack_err, timeout}); end
    endtask

    task automatic test_ack_ed;   run_good("ack_ed", 8'hED, 1'b1); endtask
    task automatic test_parity_f4; run_good("parity_f4", 8'hF4, 1'b0); endtask

    task automatic test_random;
        for (int r = 0; r < 2; r++) run_good("random", 8'($urandom), 1'b0);
    endtask

    task automatic test_noack;
        int nc, nb;
        logic [9:0] bits;
        bit ok, idle_ok;
        logic s0, s1, s2;
        logic [7:0] b;
        b = 8'($urandom);
        done_cnt = 0;
        send_wr(b);
        measure_inhibit(nc, nb);
        device_xfer(1'b0, 0, 0, bits, ok, s0, s1, s2);
        wait_idle(idle_ok);
        repeat (3) @(negedge clk);
        checks++; if (!idle_ok || busy !== 1'b0) begin errors++; $display("FAIL noack_idle got busy=%b want 0", busy); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL noack_ack_err got %b want 1", ack_err); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL noack_done got %0d want 0", done_cnt); end
        checks++; if (bits !== ref_frame(b)) begin errors++; $display("FAIL noack_frame got %b want %b", bits, ref_frame(b)); end
        send_wr(8'h3C);
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL noack_clear got %b want 0", ack_err); end
        measure_inhibit(nc, nb);
        device_xfer(1'b1, 0, 0, bits, ok, s0, s1, s2);
        wait_idle(idle_ok);
        @(negedge clk);
    endtask

    task automatic test_wr_ignored;
        int nc, nb;
        logic [9:0] bits;
        bit ok, idle_ok;
        logic s0, s1, s2;
        done_cnt = 0;
        send_wr(8'hED);
        measure_inhibit(nc, nb);
        device_xfer(1'b1, 4, 0, bits, ok, s0, s1, s2);
        wait_idle(idle_ok);
        @(negedge clk);
        checks++; if (bits !== ref_frame(8'hED)) begin errors++; $display("FAIL wr_ignored_frame got %b want %b", bits, ref_frame(8'hED)); end
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL wr_ignored_end got done=%0d busy=%b want 1 0", done_cnt, busy); end
    endtask

    task automatic test_reset_mid;
        int nc, nb;
        logic [9:0] bits;
        bit ok;
        logic s0, s1, s2;
        send_wr(8'hED);
        measure_inhibit(nc, nb);
        device_xfer(1'b1, 0, 6, bits, ok, s0, s1, s2);
        checks++; if ({s0, s1, s2} !== 3'b000) begin errors++; $display("FAIL reset_mid got clk_oe,data_oe,busy=%b want 000", {s0, s1, s2}); end
        repeat (2 * H) @(negedge clk);
        run_good("after_reset", 8'hED, 1'b1);
    endtask

    task automatic test_timeout;
`ifdef PS2_TX_TIMEOUT_EN
        int nc, nb, c;
        done_cnt = 0;
        send_wr(8'hED);
        measure_inhibit(nc, nb);
        c = 0;
        while (!timeout && c < TMO + 100) begin
            @(negedge clk);
            c++;
        end
        checks++; if (c != TMO) begin errors++; $display("FAIL timeout_delay got %0d want %0d", c, TMO); end
        checks++; if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin errors++; $display("FAIL timeout_release got %b want 000", {ps2_clk_oe, ps2_data_oe, busy}); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL timeout_done got %0d want 0", done_cnt); end
`else
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_tied got %b want 0", timeout); end
`endif
    endtask

    initial begin
        test_reset();
        test_ack_ed();
        test_parity_f4();
        test_random();
        test_noack();
        test_wr_ignored();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
